// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared ALU control codes, funct constants and sequencer state encoding
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_OR    = 2'b10,
        ALU_OP_FUNCT = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD   = 6'h21;
    localparam logic [5:0] FUNCT_SUB   = 6'h23;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_SHIFT = 6'h00;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_MUL   = 6'h19;

    // Base width of the function code; wider outputs are zero-extended.
    localparam int FN_BASE_W = 3;

    typedef enum logic [2:0] {
        FN_ADD   = 3'd0,
        FN_SUB   = 3'd1,
        FN_OR    = 3'd2,
        FN_SHIFT = 3'd3,
        FN_AND   = 3'd4,
        FN_SLT   = 3'd5,
        FN_MUL   = 3'd6,
        FN_NOP   = 3'd7
    } alu_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Multiply countdown width: enough to hold MUL_LAT-2, never narrower than 1 bit.
    function automatic int cnt_width(input int lat);
        return ($clog2(lat) < 1) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// rtl/alu_ctrl_seq_if.sv - issue/decode/handshake bundle between control unit and ALU sequencer
interface alu_ctrl_seq_if #(
    parameter int FN_W = 3
);
    logic            issue;
    logic            flush;
    logic [1:0]      ALU_OP;
    logic [5:0]      funct_ctrl;
    logic [FN_W-1:0] ALU_function;
    logic            mdu_start;
    logic            stall;
    logic            mul_done;
    logic            illegal;

    modport master (
        output issue, flush, ALU_OP, funct_ctrl,
        input  ALU_function, mdu_start, stall, mul_done, illegal
    );

    modport slave (
        input  issue, flush, ALU_OP, funct_ctrl,
        output ALU_function, mdu_start, stall, mul_done, illegal
    );
endinterface

// File: rtl/alu_funct_decode.sv
// rtl/alu_funct_decode.sv - pure combinational ALU_OP/funct to function-code decoder
module alu_funct_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ENABLE_MUL = 1
) (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_fn_e    fn,
    output logic       is_mul,
    output logic       illegal
);

    // Direct ops ignore funct; the funct table is consulted only for ALU_OP=11.
    always_comb begin
        fn      = FN_NOP;
        illegal = 1'b0;
        case (alu_op)
            ALU_OP_ADD: fn = FN_ADD;
            ALU_OP_SUB: fn = FN_SUB;
            ALU_OP_OR:  fn = FN_OR;
            default: begin
                case (funct)
                    FUNCT_ADD:   fn = FN_ADD;
                    FUNCT_SUB:   fn = FN_SUB;
                    FUNCT_OR:    fn = FN_OR;
                    FUNCT_SHIFT: fn = FN_SHIFT;
                    FUNCT_AND:   fn = FN_AND;
                    FUNCT_SLT:   fn = FN_SLT;
                    FUNCT_MUL: begin
                        if (ENABLE_MUL != 0) begin
                            fn = FN_MUL;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default:     illegal = 1'b1;
                endcase
            end
        endcase
        is_mul = (fn == FN_MUL);
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - ALU control decoder with multi-cycle multiply sequencer
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FN_W       = 3,
    parameter int MUL_LAT    = 4,
    parameter int ENABLE_MUL = 1
) (
    input  logic           clk,
    input  logic           rst,
    alu_ctrl_seq_if.slave  bus
);

    localparam int CNT_W = cnt_width(MUL_LAT);
    // Issue cycle is C0 and the first BUSY cycle is C1, so BUSY must last MUL_LAT-1 cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    alu_fn_e          op_q, op_d;

    alu_fn_e dec_fn;
    logic    dec_is_mul;
    logic    dec_illegal;

    alu_fn_e         fn_out;
    logic [FN_W-1:0] fn_ext;
    logic            start;
    logic            stall;
    logic            done;
    logic            ill;

    alu_funct_decode #(
        .ENABLE_MUL (ENABLE_MUL)
    ) u_decode (
        .alu_op  (bus.ALU_OP),
        .funct   (bus.funct_ctrl),
        .fn      (dec_fn),
        .is_mul  (dec_is_mul),
        .illegal (dec_illegal)
    );

    // Next-state and output decode: IDLE passes the live decode through, BUSY/DONE replay the latched op.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fn_out  = dec_fn;
        start   = 1'b0;
        stall   = 1'b0;
        done    = 1'b0;
        ill     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ill = bus.issue & dec_illegal;
                if (bus.issue && dec_is_mul) begin
                    start   = 1'b1;
                    stall   = 1'b1;
                    op_d    = FN_MUL;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                fn_out = op_q;
                stall  = 1'b1;
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                fn_out  = op_q;
                // A flushed op must never report completion, even in its final cycle.
                done    = ~bus.flush;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        fn_ext                  = '0;
        fn_ext[FN_BASE_W-1:0]   = fn_out;
    end

    // Sequencer state registers; reset dominates everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= FN_NOP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign bus.ALU_function = fn_ext;
    assign bus.mdu_start    = start;
    assign bus.stall        = stall;
    assign bus.mul_done     = done;
    assign bus.illegal      = ill;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - self-checking bench for alu_ctrl_seq across three parameter sets
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue;
    logic       flush;
    logic [1:0] alu_op;
    logic [5:0] funct;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Instance 0: defaults; 1: multiply disabled; 2: MUL_LAT=2 with a 4-bit function output.
    int lat [3] = '{4, 4, 2};
    bit en  [3] = '{1'b1, 1'b0, 1'b1};
    bit active [3] = '{1'b0, 1'b0, 1'b0};
    int t0 [3]     = '{0, 0, 0};

    always #5 clk = ~clk;

    alu_ctrl_seq_if #(.FN_W(3)) if_a ();
    alu_ctrl_seq_if #(.FN_W(3)) if_b ();
    alu_ctrl_seq_if #(.FN_W(4)) if_c ();

    assign if_a.issue = issue;  assign if_a.flush = flush;
    assign if_a.ALU_OP = alu_op; assign if_a.funct_ctrl = funct;
    assign if_b.issue = issue;  assign if_b.flush = flush;
    assign if_b.ALU_OP = alu_op; assign if_b.funct_ctrl = funct;
    assign if_c.issue = issue;  assign if_c.flush = flush;
    assign if_c.ALU_OP = alu_op; assign if_c.funct_ctrl = funct;

    alu_ctrl_seq #(.FN_W(3), .MUL_LAT(4), .ENABLE_MUL(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    alu_ctrl_seq #(.FN_W(3), .MUL_LAT(4), .ENABLE_MUL(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    alu_ctrl_seq #(.FN_W(4), .MUL_LAT(2), .ENABLE_MUL(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    typedef struct {
        bit         iss;
        logic [1:0] op;
        logic [5:0] f;
        logic [2:0] fn_en;
        logic [2:0] fn_dis;
        bit         ill_en;
        bit         ill_dis;
    } vec_t;

    vec_t vt [12];

    function automatic logic [2:0] ref_fn(input logic [1:0] op, input logic [5:0] f, input bit mul_ok);
        if (op == 2'b00) return 3'd0;
        if (op == 2'b01) return 3'd1;
        if (op == 2'b10) return 3'd2;
        case (f)
            6'h21: return 3'd0;
            6'h23: return 3'd1;
            6'h25: return 3'd2;
            6'h00: return 3'd3;
            6'h24: return 3'd4;
            6'h2A: return 3'd5;
            6'h19: return mul_ok ? 3'd6 : 3'd7;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [3:0] act_fn(input int i);
        case (i)
            0:       return {1'b0, if_a.ALU_function};
            1:       return {1'b0, if_b.ALU_function};
            default: return if_c.ALU_function;
        endcase
    endfunction

    // {mdu_start, stall, mul_done, illegal}
    function automatic logic [3:0] act_flags(input int i);
        case (i)
            0:       return {if_a.mdu_start, if_a.stall, if_a.mul_done, if_a.illegal};
            1:       return {if_b.mdu_start, if_b.stall, if_b.mul_done, if_b.illegal};
            default: return {if_c.mdu_start, if_c.stall, if_c.mul_done, if_c.illegal};
        endcase
    endfunction

    task automatic cmp(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, idx, cyc, act, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then check every instance against the reference model.
    task automatic drive(input bit r, input bit iss, input bit fl, input logic [1:0] op, input logic [5:0] f);
        rst = r; issue = iss; flush = fl; alu_op = op; funct = f;
        #3;
        for (int i = 0; i < 3; i++) begin
            logic [2:0] d;
            logic [3:0] e_fn;
            bit e_sta, e_st, e_dn, e_il;
            int k;
            d = ref_fn(op, f, en[i]);
            if (active[i]) begin
                k     = cyc - t0[i];
                e_fn  = 4'd6;
                e_sta = 1'b0;
                e_st  = (k < lat[i]);
                e_dn  = (k == lat[i]) && !fl;
                e_il  = 1'b0;
            end else begin
                e_fn  = {1'b0, d};
                e_sta = iss && (d == 3'd6);
                e_st  = e_sta;
                e_dn  = 1'b0;
                e_il  = iss && (d == 3'd7);
            end
            cmp("model_fn", i, act_fn(i), e_fn);
            cmp("model_flags", i, act_flags(i), {e_sta, e_st, e_dn, e_il});
        end
    endtask

    // Advance the model by one cycle and move to just after the next rising edge.
    task automatic tick();
        for (int i = 0; i < 3; i++) begin
            if (active[i]) begin
                if (rst || flush || (cyc - t0[i] >= lat[i])) active[i] = 1'b0;
            end else if (!rst && issue && ref_fn(alu_op, funct, en[i]) == 3'd6) begin
                active[i] = 1'b1;
                t0[i]     = cyc;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{1'b1, 2'b11, 6'h21, 3'd0, 3'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 2'b11, 6'h23, 3'd1, 3'd1, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 2'b11, 6'h25, 3'd2, 3'd2, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 2'b11, 6'h00, 3'd3, 3'd3, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 2'b11, 6'h24, 3'd4, 3'd4, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 2'b11, 6'h2A, 3'd5, 3'd5, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 2'b11, 6'h19, 3'd6, 3'd7, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 2'b11, 6'h3F, 3'd7, 3'd7, 1'b1, 1'b1};
        vt[8]  = '{1'b1, 2'b10, 6'h3F, 3'd2, 3'd2, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 2'b00, 6'h19, 3'd0, 3'd0, 1'b0, 1'b0};
        vt[10] = '{1'b1, 2'b01, 6'h2A, 3'd1, 3'd1, 1'b0, 1'b0};
        vt[11] = '{1'b1, 2'b11, 6'h22, 3'd7, 3'd7, 1'b1, 1'b1};

        rst = 1'b1; issue = 1'b0; flush = 1'b0; alu_op = 2'b00; funct = 6'h00;
        @(posedge clk);
        #1;

        // Reset held two cycles: everything reads zero.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 2'b00, 6'h00);
            for (int i = 0; i < 3; i++) begin
                cmp("rst_fn", i, act_fn(i), 4'd0);
                cmp("rst_flags", i, act_flags(i), 4'b0000);
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 2'b11, 6'h23);
        cmp("sub_fn", 0, act_fn(0), 4'd1);
        cmp("sub_stall", 0, {3'b0, if_a.stall}, 4'd0);
        tick();

        // Decode table.
        for (int j = 0; j < 12; j++) begin
            drive(1'b0, vt[j].iss, 1'b0, vt[j].op, vt[j].f);
            cmp("tbl_fn_a", j, act_fn(0), {1'b0, vt[j].fn_en});
            cmp("tbl_fn_b", j, act_fn(1), {1'b0, vt[j].fn_dis});
            cmp("tbl_fn_c", j, act_fn(2), {1'b0, vt[j].fn_en});
            cmp("tbl_ill_a", j, {3'b0, if_a.illegal}, {3'b0, vt[j].ill_en});
            cmp("tbl_ill_b", j, {3'b0, if_b.illegal}, {3'b0, vt[j].ill_dis});
            cmp("tbl_stall_a", j, {3'b0, if_a.stall}, 4'd0);
            tick();
        end

        // Full multiply: latency 4 on a, latency 2 on c, rejected on b.
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, k == 0, 1'b0, 2'b11, 6'h19);
            cmp("mul_a", k, act_flags(0), {k == 0, k <= 3, k == 4, 1'b0});
            cmp("mul_a_fn", k, act_fn(0), 4'd6);
            cmp("mul_b", k, act_flags(1), {1'b0, 1'b0, 1'b0, k == 0});
            cmp("mul_b_fn", k, act_fn(1), 4'd7);
            cmp("mul_c", k, act_flags(2), {k == 0, k <= 1, k == 2, 1'b0});
            tick();
        end

        // Flush in the middle of BUSY.
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, k == 0, k == 2, (k == 0) ? 2'b11 : 2'b00, (k == 0) ? 6'h19 : 6'h00);
            cmp("flush_stall", k, {3'b0, if_a.stall}, {3'b0, k <= 2});
            cmp("flush_done", k, {3'b0, if_a.mul_done}, 4'd0);
            tick();
        end

        // Reset in the first BUSY cycle.
        for (int k = 0; k < 7; k++) begin
            drive(k == 1, k == 0, 1'b0, (k == 0) ? 2'b11 : 2'b00, (k == 0) ? 6'h19 : 6'h00);
            if (k >= 2) begin
                cmp("rstmid_fn", k, act_fn(0), 4'd0);
                cmp("rstmid_flags", k, act_flags(0), 4'b0000);
            end
            tick();
        end

        // Flush coinciding with counter expiry (last BUSY cycle).
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, k == 0, k == 3, (k == 0) ? 2'b11 : 2'b00, (k == 0) ? 6'h19 : 6'h00);
            cmp("flexp_stall", k, {3'b0, if_a.stall}, {3'b0, k <= 3});
            cmp("flexp_done", k, {3'b0, if_a.mul_done}, 4'd0);
            tick();
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic [1:0] op;
            logic [5:0] f;
            bit r, iss, fl;
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) op = 2'b11;
            case ($urandom_range(0, 7))
                0: f = 6'h21;
                1: f = 6'h23;
                2: f = 6'h25;
                3: f = 6'h00;
                4: f = 6'h24;
                5: f = 6'h2A;
                6: f = 6'h19;
                default: f = 6'($urandom);
            endcase
            iss = ($urandom_range(0, 1) == 1);
            fl  = ($urandom_range(0, 19) == 0);
            r   = ($urandom_range(0, 49) == 0);
            drive(r, iss, fl, op, f);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
